pwm_capture: RTL and testbench

//  Receive-side counterpart of the PWM controller: samples NUM_CHANNELS PWM outputs plus the

---
 rtl/pwm_capture_if.sv | 24 ++
 rtl/pwm_capture.sv | 164 ++++++++++++++++
 tb/tb_pwm_capture.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source/monitor harness and the pwm_capture block.
// The master drives the PWM channels and period strobe; the slave returns the recovered results.
interface pwm_capture_if #(
  parameter int NUM_CHANNELS = 16,
  parameter int PERIOD_BITS  = 8
);
  logic                                     start;
  logic [NUM_CHANNELS-1:0]                  pwm_in;
  logic [NUM_CHANNELS-1:0][PERIOD_BITS-1:0] phase;
  logic [NUM_CHANNELS-1:0][6:0]             amp;
  logic                                     valid;
  logic                                     locked;
  logic                                     err;

  modport master (
    output start, pwm_in,
    input  phase, amp, valid, locked, err
  );

  modport slave (
    input  start, pwm_in,
    output phase, amp, valid, locked, err
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM loopback monitor: recovers per-channel rising-edge phase and high-time amplitude every period.
// Define PWM_CAP_SYNC_EN to pass pwm_in and start through a 2-flop synchronizer before all logic.
module pwm_capture #(
  parameter int NUM_CHANNELS = 16,
  parameter int PERIOD_BITS  = 8,
  parameter int AMP_SHIFT    = 1
) (
  input  logic         clk,
  input  logic         nReset,
  pwm_capture_if.slave cap
);

  localparam int CW = PERIOD_BITS + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((2 ** PERIOD_BITS) - 1);
  localparam logic [CW-1:0] OVER_CNT = CW'(2 ** PERIOD_BITS);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

  state_t                                   state_q, state_d;
  logic [CW-1:0]                            cnt_q, cnt_d;
  logic                                     valid_q, valid_d;
  logic                                     locked_q, locked_d;
  logic                                     err_q, err_d;
  logic                                     publish;
  logic [NUM_CHANNELS-1:0]                  prev_q, prev_d;
  logic [NUM_CHANNELS-1:0]                  seen_q, seen_d;
  logic [NUM_CHANNELS-1:0]                  rise;
  logic [NUM_CHANNELS-1:0][PERIOD_BITS-1:0] first_rise_q, first_rise_d;
  logic [NUM_CHANNELS-1:0][PERIOD_BITS-1:0] phase_q, phase_d;
  logic [NUM_CHANNELS-1:0][CW-1:0]          hi_cnt_q, hi_cnt_d;
  logic [NUM_CHANNELS-1:0][6:0]             amp_q, amp_d;
  logic                                     s_start;
  logic [NUM_CHANNELS-1:0]                  s_pwm;

`ifdef PWM_CAP_SYNC_EN
  logic [NUM_CHANNELS:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = {cap.start, cap.pwm_in};
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign {s_start, s_pwm} = sync2_q;
`else
  assign s_start = cap.start;
  assign s_pwm   = cap.pwm_in;
`endif

  function automatic logic [6:0] amp_code(input logic [CW-1:0] hi);
    logic [CW-1:0] shifted;
    shifted = hi >> AMP_SHIFT;
    return (shifted > CW'(127)) ? 7'd127 : shifted[6:0];
  endfunction

  // A start closes the running period; only a full-length period seen while tracking is published.
  always_comb begin
    cnt_d    = s_start ? '0 : cnt_q + 1'b1;
    state_d  = state_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    valid_d  = 1'b0;
    publish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_start) state_d = ACQUIRE;
      end
      ACQUIRE, TRACK: begin
        if (s_start) begin
          if (cnt_q == LAST_CNT) begin
            state_d = TRACK;
            if (state_q == TRACK) begin
              publish  = 1'b1;
              valid_d  = 1'b1;
              locked_d = 1'b1;
            end
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = ACQUIRE;
          end
        end else if (cnt_q == OVER_CNT) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // prev survives the period boundary so a pulse straddling start is not seen as a new rise.
  assign rise = s_pwm & ~prev_q;

  always_comb begin
    prev_d       = s_pwm;
    seen_d       = seen_q;
    first_rise_d = first_rise_q;
    hi_cnt_d     = hi_cnt_q;
    phase_d      = phase_q;
    amp_d        = amp_q;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (s_start) begin
        hi_cnt_d[ch]     = CW'(s_pwm[ch]);
        seen_d[ch]       = rise[ch];
        first_rise_d[ch] = '0;
      end else begin
        hi_cnt_d[ch] = hi_cnt_q[ch] + CW'(s_pwm[ch]);
        if (rise[ch] && !seen_q[ch]) begin
          seen_d[ch]       = 1'b1;
          first_rise_d[ch] = cnt_d[PERIOD_BITS-1:0];
        end
      end
      if (publish) begin
        phase_d[ch] = seen_q[ch] ? first_rise_q[ch] : '0;
        amp_d[ch]   = amp_code(hi_cnt_q[ch]);
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      prev_q       <= '0;
      seen_q       <= '0;
      first_rise_q <= '0;
      hi_cnt_q     <= '0;
      phase_q      <= '0;
      amp_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      prev_q       <= prev_d;
      seen_q       <= seen_d;
      first_rise_q <= first_rise_d;
      hi_cnt_q     <= hi_cnt_d;
      phase_q      <= phase_d;
      amp_q        <= amp_d;
    end
  end

  assign cap.phase  = phase_q;
  assign cap.amp    = amp_q;
  assign cap.valid  = valid_q;
  assign cap.locked = locked_q;
  assign cap.err    = err_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: a waveform-level model predicts every output each cycle.
// Compile with PWM_CAP_SYNC_EN defined to match a synchronizer build of the design.
module tb_pwm_capture;

  localparam int NCH       = 16;
  localparam int PB        = 8;
  localparam int PERIOD    = 256;
  localparam int AMP_SHIFT = 1;

  logic clk    = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  pwm_capture_if #(.NUM_CHANNELS(NCH), .PERIOD_BITS(PB)) cap ();

  pwm_capture #(
    .NUM_CHANNELS(NCH),
    .PERIOD_BITS (PB),
    .AMP_SHIFT   (AMP_SHIFT)
  ) dut (
    .clk   (clk),
    .nReset(nReset),
    .cap   (cap)
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int valid_seen    = 0;
  int err_seen      = 0;
  bit compare_en    = 1'b0;

  int rise_cfg [NCH];
  int len_cfg  [NCH];

  // Reference model state: the raw waveform of the running period plus period-length bookkeeping.
  logic [NCH-1:0]         wave [$];
  logic [NCH-1:0]         pre_sample, last_sample;
  logic [NCH-1:0]         d1, d2;
  logic                   ds1, ds2;
  bit                     in_seq;
  int                     pos;
  int                     good_run;
  logic                   exp_valid, exp_locked, exp_err;
  logic [NCH-1:0][PB-1:0] exp_phase;
  logic [NCH-1:0][6:0]    exp_amp;

  task automatic checkField(input string name, input logic [127:0] act, input logic [127:0] req);
    checks_total++;
    if (act === req) checks_passed++;
    else $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
  endtask

  task automatic modelClear();
    wave.delete();
    pre_sample  = '0;
    last_sample = '0;
    d1 = '0; d2 = '0; ds1 = 1'b0; ds2 = 1'b0;
    in_seq = 1'b0; pos = 0; good_run = 0;
    exp_valid = 1'b0; exp_locked = 1'b0; exp_err = 1'b0;
    exp_phase = '0; exp_amp = '0;
  endtask

  // Phase = index of first 0->1 transition in the period, amp = number of high samples scaled.
  task automatic modelPublish();
    int   ones;
    int   ph;
    bit   found;
    logic prevb;
    for (int c = 0; c < NCH; c++) begin
      ones = 0; ph = 0; found = 1'b0;
      for (int i = 0; i < wave.size(); i++) begin
        prevb = (i == 0) ? pre_sample[c] : wave[i-1][c];
        if (wave[i][c]) ones++;
        if (!found && wave[i][c] && !prevb) begin
          found = 1'b1;
          ph    = i;
        end
      end
      exp_phase[c] = PB'(ph);
      exp_amp[c]   = ((ones >> AMP_SHIFT) > 127) ? 7'd127 : 7'(ones >> AMP_SHIFT);
    end
  endtask

  task automatic modelStep();
    logic           st;
    logic [NCH-1:0] pw;
`ifdef PWM_CAP_SYNC_EN
    st = ds2; pw = d2;
    ds2 = ds1; d2 = d1;
    ds1 = cap.start; d1 = cap.pwm_in;
`else
    st = cap.start; pw = cap.pwm_in;
`endif
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (st) begin
      if (!in_seq) begin
        in_seq   = 1'b1;
        good_run = 0;
      end else if (pos + 1 == PERIOD) begin
        good_run++;
        if (good_run >= 2) begin
          modelPublish();
          exp_valid  = 1'b1;
          exp_locked = 1'b1;
        end
      end else begin
        exp_err    = 1'b1;
        exp_locked = 1'b0;
        good_run   = 0;
      end
      pre_sample = last_sample;
      wave.delete();
      wave.push_back(pw);
      pos = 0;
    end else begin
      pos++;
      if (wave.size() < 600) wave.push_back(pw);
      if (in_seq && pos == PERIOD + 1) begin
        exp_err    = 1'b1;
        exp_locked = 1'b0;
        in_seq     = 1'b0;
        good_run   = 0;
      end
    end
    last_sample = pw;
  endtask

  initial begin
    modelClear();
    forever begin
      @(posedge clk or negedge nReset);
      if (!nReset) modelClear();
      else modelStep();
    end
  end

  task automatic checkOutput();
    checkField("valid",  128'(cap.valid),  128'(exp_valid));
    checkField("locked", 128'(cap.locked), 128'(exp_locked));
    checkField("err",    128'(cap.err),    128'(exp_err));
    checkField("phase",  128'(cap.phase),  128'(exp_phase));
    checkField("amp",    128'(cap.amp),    128'(exp_amp));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (compare_en) begin
        checkOutput();
        if (cap.valid === 1'b1) valid_seen++;
        if (cap.err === 1'b1) err_seen++;
      end
    end
  end

  function automatic logic [NCH-1:0] waveAt(input int o);
    logic [NCH-1:0] w;
    int             d;
    for (int c = 0; c < NCH; c++) begin
      d    = ((o - rise_cfg[c]) % PERIOD + PERIOD) % PERIOD;
      w[c] = (d < len_cfg[c]);
    end
    return w;
  endfunction

  task automatic applyStimulus(input logic st, input logic [NCH-1:0] pw);
    @(negedge clk);
    cap.start  = st;
    cap.pwm_in = pw;
  endtask

  task automatic runPeriod(input int len, input bit with_start);
    for (int o = 0; o < len; o++) applyStimulus(with_start && (o == 0), waveAt(o));
  endtask

  initial begin
    int vbase;
    int ebase;
    cap.start  = 1'b0;
    cap.pwm_in = '0;
    for (int c = 0; c < NCH; c++) begin
      rise_cfg[c] = 0;
      len_cfg[c]  = (c < 15) ? 248 - 16 * c : 2;
    end

    // Reset held with toggling inputs
    @(posedge clk);
    compare_en = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(1'($urandom_range(0, 1)), NCH'($urandom));
    #1;
    checkField("rst_valid",  128'(cap.valid),  128'(0));
    checkField("rst_locked", 128'(cap.locked), 128'(0));
    checkField("rst_phase",  128'(cap.phase),  128'(0));
    checkField("rst_amp",    128'(cap.amp),    128'(0));
    applyStimulus(1'b0, '0);
    @(posedge clk); #2 nReset = 1'b1;

    // Zero phases, graded amplitudes; no publish before two full periods
    vbase = valid_seen;
    runPeriod(PERIOD, 1'b1);
    runPeriod(PERIOD, 1'b1);
    #1 checkField("early_valid_cnt", 128'(valid_seen - vbase), 128'(0));
    runPeriod(PERIOD, 1'b1);
    runPeriod(PERIOD, 1'b1);
    #1;
    checkField("t2_valid_cnt", 128'(valid_seen - vbase), 128'(2));
    checkField("t2_locked", 128'(cap.locked), 128'(1));
    checkField("t2_amp0",   128'(cap.amp[0]),  128'(124));
    checkField("t2_amp14",  128'(cap.amp[14]), 128'(12));
    checkField("t2_amp15",  128'(cap.amp[15]), 128'(1));
    checkField("t2_phase3", 128'(cap.phase[3]), 128'(0));
    checkField("t2_model_amp0", 128'(exp_amp[0]), 128'(124));

    // Staggered phases, 64-clock pulses; ch15 straddles the period boundary
    for (int c = 0; c < NCH; c++) begin
      rise_cfg[c] = 16 * c;
      len_cfg[c]  = 64;
    end
    for (int i = 0; i < 3; i++) runPeriod(PERIOD, 1'b1);
    #1;
    checkField("t3_phase1",  128'(cap.phase[1]),  128'(16));
    checkField("t3_phase5",  128'(cap.phase[5]),  128'(80));
    checkField("t3_amp5",    128'(cap.amp[5]),    128'(32));
    checkField("t3_phase15", 128'(cap.phase[15]), 128'(240));
    checkField("t3_amp15",   128'(cap.amp[15]),   128'(32));
    checkField("t3_model_phase15", 128'(exp_phase[15]), 128'(240));

    // Stuck-high and stuck-low channels
    rise_cfg[0] = 0; len_cfg[0] = PERIOD;
    rise_cfg[1] = 0; len_cfg[1] = 0;
    for (int i = 0; i < 3; i++) runPeriod(PERIOD, 1'b1);
    #1;
    checkField("t4_phase0", 128'(cap.phase[0]), 128'(0));
    checkField("t4_amp0",   128'(cap.amp[0]),   128'(127));
    checkField("t4_phase1", 128'(cap.phase[1]), 128'(0));
    checkField("t4_amp1",   128'(cap.amp[1]),   128'(0));
    checkField("t4_model_amp0", 128'(exp_amp[0]), 128'(127));

    // Early start at count 200, then recovery
    runPeriod(200, 1'b1);
    vbase = valid_seen;
    ebase = err_seen;
    runPeriod(PERIOD, 1'b1);
    #1;
    checkField("t5_err_cnt",  128'(err_seen - ebase), 128'(1));
    checkField("t5_locked",   128'(cap.locked), 128'(0));
    runPeriod(PERIOD, 1'b1);
    #1 checkField("t5_no_valid", 128'(valid_seen - vbase), 128'(0));
    runPeriod(PERIOD, 1'b1);
    #1;
    checkField("t5_relock",     128'(cap.locked), 128'(1));
    checkField("t5_valid_cnt",  128'(valid_seen - vbase), 128'(1));

    // Start strobe lost: timeout, then relock
    ebase = err_seen;
    runPeriod(300, 1'b0);
    #1;
    checkField("t6_err_cnt", 128'(err_seen - ebase), 128'(1));
    checkField("t6_locked",  128'(cap.locked), 128'(0));
    vbase = valid_seen;
    for (int i = 0; i < 3; i++) runPeriod(PERIOD, 1'b1);
    #1;
    checkField("t6_relock",    128'(cap.locked), 128'(1));
    checkField("t6_valid_cnt", 128'(valid_seen - vbase), 128'(1));

    // Reset mid-period discards everything
    runPeriod(100, 1'b1);
    @(posedge clk); #2 nReset = 1'b0;
    @(negedge clk); #1;
    checkField("mid_rst_locked", 128'(cap.locked), 128'(0));
    checkField("mid_rst_amp",    128'(cap.amp),    128'(0));
    checkField("mid_rst_phase",  128'(cap.phase),  128'(0));
    repeat (3) @(negedge clk);
    compare_en = 1'b0;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
